// File: rtl/loader_pkg.sv
// Shared types and helpers for the SPI flash loader stream path.
package loader_pkg;

   localparam int FIFO_W = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      WAIT_LD = 3'd2,
      RUN     = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Number of FIFO words needed to carry len items of out_w bits each.
   function automatic logic [31:0] words_for(input logic [31:0] len, input int out_w);
      logic [31:0] bits_v;
      bits_v = len * 32'(out_w);
      return (bits_v + 32'(FIFO_W - 1)) / 32'(FIFO_W);
   endfunction

endpackage

// File: rtl/loader_stream_unpacker.sv
// Pops 32-bit words from the loader FIFO and streams them out as OUT_W-bit
// items on a valid/ready interface, tracking the requested item count.
module loader_stream_unpacker
   import loader_pkg::*;
#(
   parameter int OUT_W = 8,
   parameter int LEN_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_init,
   output logic             o_fill,
   input  logic             i_load_done,
   input  logic             i_fifo_empty,
   output logic             o_fifo_rd,
   input  logic [31:0]      i_fifo_dout,
   output logic             o_valid,
   output logic [OUT_W-1:0] o_data,
   output logic             o_last,
   input  logic             i_ready
);

   localparam int SLOTS = FIFO_W / OUT_W;
   localparam int CNT_W = $clog2(SLOTS + 1);

   state_t            state_r;
   logic [LEN_W-1:0]  items_left_r;
   logic [LEN_W-1:0]  words_left_r;
   logic [FIFO_W-1:0] hold_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              rd_pend_r;
   logic              busy_r;
   logic              done_r;
   logic              init_r;

   logic              accept_s;
   logic              pop_s;
   logic [LEN_W-1:0]  items_after_s;
   logic [CNT_W-1:0]  refill_cnt_s;

   // Handshake, pop decision and refill slot count for the current cycle.
   always_comb begin
      accept_s = (cnt_r != CNT_W'(0)) && i_ready;

      // A word may be popped while the last held slot leaves, keeping at most one read in flight.
      if ((state_r == RUN) && !i_abort && (words_left_r != LEN_W'(0)) && !i_fifo_empty &&
          !rd_pend_r && ((cnt_r == CNT_W'(0)) || ((cnt_r == CNT_W'(1)) && i_ready))) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end

      if (accept_s) begin
         items_after_s = items_left_r - LEN_W'(1);
      end else begin
         items_after_s = items_left_r;
      end

      // The final word may be partial; slots beyond the request are never presented.
      if (items_after_s >= LEN_W'(SLOTS)) begin
         refill_cnt_s = CNT_W'(SLOTS);
      end else begin
         refill_cnt_s = items_after_s[CNT_W-1:0];
      end
   end

   // Control FSM: request bookkeeping plus the init/done/busy outputs.
   always_ff @(posedge clk) begin
      if (reset || i_abort) begin
         state_r      <= IDLE;
         items_left_r <= LEN_W'(0);
         words_left_r <= LEN_W'(0);
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         init_r       <= 1'b0;
      end else begin
         init_r <= 1'b0;
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (i_start && (i_len == LEN_W'(0))) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b1;
               end else if (i_start) begin
                  items_left_r <= i_len;
                  words_left_r <= LEN_W'(words_for(32'(i_len), OUT_W));
                  state_r      <= INIT;
                  init_r       <= 1'b1;
                  busy_r       <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            INIT: begin
               state_r <= WAIT_LD;
            end
            WAIT_LD: begin
               if (i_load_done) begin
                  state_r <= RUN;
               end else begin
                  state_r <= WAIT_LD;
               end
            end
            RUN: begin
               if (pop_s) begin
                  words_left_r <= words_left_r - LEN_W'(1);
               end
               items_left_r <= items_after_s;
               if (accept_s && (items_left_r == LEN_W'(1))) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Slicer: captures popped words and shifts one item out per accept.
   always_ff @(posedge clk) begin
      if (reset || i_abort) begin
         hold_r    <= FIFO_W'(0);
         cnt_r     <= CNT_W'(0);
         rd_pend_r <= 1'b0;
      end else begin
         rd_pend_r <= pop_s;
         if (rd_pend_r) begin
            hold_r <= i_fifo_dout;
            cnt_r  <= refill_cnt_s;
         end else if (accept_s) begin
            hold_r <= hold_r >> OUT_W;
            cnt_r  <= cnt_r - CNT_W'(1);
         end else begin
            hold_r <= hold_r;
            cnt_r  <= cnt_r;
         end
      end
   end

   assign o_busy    = busy_r;
   assign o_done    = done_r;
   assign o_init    = init_r;
   assign o_fill    = (state_r == RUN) && (words_left_r != LEN_W'(0));
   assign o_fifo_rd = pop_s;
   assign o_valid   = (cnt_r != CNT_W'(0));
   assign o_data    = hold_r[OUT_W-1:0];
   assign o_last    = (cnt_r != CNT_W'(0)) && (items_left_r == LEN_W'(1));

endmodule

// File: tb/tb_loader_stream_unpacker.sv
// Randomized bench for loader_stream_unpacker: both item widths share one FIFO
// model; expected items come from slicing the stored words by index.
module tb_loader_stream_unpacker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, abort, load_done, ready, force_empty, fifo_clr, sel;
   logic [23:0] len;
   logic [31:0] fifo_dout;
   logic [31:0] fmem [0:63];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        fifo_empty;

   logic        busy8, done8, init8, fill8, rd8, valid8, last8;
   logic [7:0]  data8;
   logic        busy16, done16, init16, fill16, rd16, valid16, last16;
   logic [15:0] data16;

   logic        busy_s, done_s, init_s, fill_s, rd_s, valid_s, last_s;
   logic [15:0] data_s;

   int total = 0;
   int bad   = 0;

   assign fifo_empty = force_empty || (rd_ptr == wr_ptr);
   assign busy_s  = sel ? busy16  : busy8;
   assign done_s  = sel ? done16  : done8;
   assign init_s  = sel ? init16  : init8;
   assign fill_s  = sel ? fill16  : fill8;
   assign rd_s    = sel ? rd16    : rd8;
   assign valid_s = sel ? valid16 : valid8;
   assign last_s  = sel ? last16  : last8;
   assign data_s  = sel ? data16  : {8'h00, data8};

   loader_stream_unpacker #(.OUT_W(8), .LEN_W(24)) dut8 (
      .clk(clk), .reset(reset), .i_start(start & ~sel), .i_len(len), .i_abort(abort),
      .o_busy(busy8), .o_done(done8), .o_init(init8), .o_fill(fill8),
      .i_load_done(load_done), .i_fifo_empty(fifo_empty), .o_fifo_rd(rd8),
      .i_fifo_dout(fifo_dout), .o_valid(valid8), .o_data(data8), .o_last(last8),
      .i_ready(ready)
   );

   loader_stream_unpacker #(.OUT_W(16), .LEN_W(24)) dut16 (
      .clk(clk), .reset(reset), .i_start(start & sel), .i_len(len), .i_abort(abort),
      .o_busy(busy16), .o_done(done16), .o_init(init16), .o_fill(fill16),
      .i_load_done(load_done), .i_fifo_empty(fifo_empty), .o_fifo_rd(rd16),
      .i_fifo_dout(fifo_dout), .o_valid(valid16), .o_data(data16), .o_last(last16),
      .i_ready(ready)
   );

   // FIFO model: read data appears the cycle after a pop, garbage otherwise.
   always @(posedge clk) begin
      if (fifo_clr) begin
         rd_ptr    <= 0;
         fifo_dout <= 32'hDEAD_BEEF;
      end else if (rd8 || rd16) begin
         fifo_dout <= fmem[rd_ptr[5:0]];
         rd_ptr    <= rd_ptr + 1;
      end else begin
         fifo_dout <= 32'hDEAD_BEEF;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_req(input bit w16, input int n, input int rdy_mode,
                          input int empty_at, input int abort_at, input bit rand_words);
      int          w, slots, nwords, nwait, pops, idx, empty_left, cyc;
      bit          stall_q, pop1, pop2, finished, aborted, empty_done;
      logic [15:0] data_q;
      logic        last_q;
      logic [31:0] mask;
      logic [15:0] exp_q[$];

      w      = w16 ? 16 : 8;
      slots  = 32 / w;
      mask   = w16 ? 32'h0000_FFFF : 32'h0000_00FF;
      nwords = (n * w + 31) / 32;
      sel    = w16;
      if (rand_words) begin
         for (int i = 0; i < nwords; i++) fmem[i] = $urandom();
      end
      fmem[nwords] = $urandom();
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(16'((fmem[i / slots] >> (w * (i % slots))) & mask));

      @(negedge clk);
      fifo_clr = 1'b1;
      @(negedge clk);
      fifo_clr = 1'b0;
      wr_ptr   = nwords + 1;

      @(negedge clk);
      start = 1'b1;
      len   = 24'(n);
      @(negedge clk);
      start = 1'b0;
      #1;
      if (n == 0) begin
         check_eq("zero_done", 32'(done_s), 32'd1);
         check_eq("zero_init", 32'(init_s), 32'd0);
         check_eq("zero_fill", 32'(fill_s | rd_s), 32'd0);
         @(negedge clk);
         #1;
         check_eq("zero_done_pulse", 32'(done_s), 32'd0);
         check_eq("zero_idle", 32'(busy_s | rd_s | init_s), 32'd0);
         return;
      end
      check_eq("init_t1", 32'(init_s), 32'd1);
      check_eq("busy_t1", 32'(busy_s), 32'd1);

      nwait = $urandom_range(0, 4);
      for (int k = 0; k <= nwait; k++) begin
         @(negedge clk);
         #1;
         if (k == 0) check_eq("init_pulse", 32'(init_s), 32'd0);
         check_eq("wait_rd", 32'(rd_s | fill_s | valid_s), 32'd0);
      end
      @(negedge clk);
      load_done = 1'b1;
      #1;
      check_eq("ld_cycle_rd", 32'(rd_s), 32'd0);

      pops = 0; idx = 0; empty_left = 0; cyc = 0;
      stall_q = 0; pop1 = 0; pop2 = 0; finished = 0; aborted = 0; empty_done = 0;
      data_q = 16'h0000; last_q = 1'b0;
      while (!finished && !aborted && cyc < 3000) begin
         @(negedge clk);
         load_done = 1'b0;
         case (rdy_mode)
            0:       ready = 1'b1;
            1:       ready = (cyc % 2 == 0);
            2:       ready = 1'($urandom_range(0, 1));
            default: ready = (cyc >= 8 && cyc < 18) ? 1'b0 : (cyc % 2 == 0);
         endcase
         force_empty = (empty_left > 0);
         if (empty_left > 0) empty_left--;
         abort = (abort_at > 0) && pop1 && (pops == abort_at);
         cyc++;
         #1;
         if (abort) begin
            aborted = 1;
            continue;
         end
         if (fifo_empty) check_eq("rd_when_empty", 32'(rd_s), 32'd0);
         check_eq("fill", 32'(fill_s), 32'(pops < nwords));
         check_eq("done_early", 32'(done_s), 32'd0);
         if (pop2) check_eq("pop_to_valid", 32'(valid_s), 32'd1);
         if (pop1) check_eq("pop_gap", 32'(valid_s), 32'd0);
         if (stall_q) begin
            check_eq("stall_valid", 32'(valid_s), 32'd1);
            check_eq("stall_data", 32'(data_s), 32'(data_q));
            check_eq("stall_last", 32'(last_s), 32'(last_q));
         end
         if (rd_s) begin
            check_eq("pop_legal", 32'((!valid_s || (ready && (idx % slots == slots - 1))) && (pops < nwords)), 32'd1);
            pops++;
         end
         if (valid_s && ready) begin
            check_eq("item", 32'(data_s), 32'(exp_q[idx]));
            check_eq("last", 32'(last_s), 32'(idx == n - 1));
            idx++;
            if (idx == n) finished = 1;
         end
         stall_q = valid_s && !ready;
         data_q  = data_s;
         last_q  = last_s;
         pop2    = pop1;
         pop1    = rd_s;
         if (empty_at > 0 && pops == empty_at && !empty_done) begin
            empty_left = 20;
            empty_done = 1;
         end
      end
      force_empty = 1'b0;

      if (aborted) begin
         @(negedge clk);
         abort = 1'b0;
         #1;
         check_eq("abort_idle", 32'(busy_s), 32'd0);
         check_eq("abort_valid", 32'(valid_s | done_s), 32'd0);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check_eq("abort_quiet", 32'(valid_s | done_s | rd_s), 32'd0);
         end
      end else if (finished) begin
         @(negedge clk);
         #1;
         check_eq("done_f1", 32'(done_s), 32'd1);
         check_eq("done_busy_f1", 32'(busy_s & ~valid_s), 32'd1);
         @(negedge clk);
         #1;
         check_eq("done_f2", 32'(done_s), 32'd0);
         check_eq("idle_f2", 32'(busy_s), 32'd0);
         check_eq("pop_count", 32'(pops), 32'(nwords));
      end else begin
         check_eq("timeout_items", 32'(idx), 32'(n));
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; load_done = 1'b0; ready = 1'b0;
      force_empty = 1'b0; fifo_clr = 1'b1; sel = 1'b0; len = 24'd0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_w8", {17'd0, busy8, done8, init8, fill8, rd8, valid8, last8, data8}, 32'd0);
      check_eq("reset_w16", {9'd0, busy16, done16, init16, fill16, rd16, valid16, last16, data16}, 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      fifo_clr = 1'b0;

      // Abort wins over a simultaneous start.
      @(negedge clk);
      start = 1'b1; abort = 1'b1; len = 24'd5;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1;
      check_eq("abort_over_start", 32'(busy8 | init8), 32'd0);

      fmem[0] = 32'h4433_2211;
      fmem[1] = 32'h8877_6655;
      run_req(1'b0, 6, 0, 0, 0, 1'b0);
      fmem[0] = 32'hBBBB_AAAA;
      fmem[1] = 32'hDDDD_CCCC;
      run_req(1'b1, 3, 0, 0, 0, 1'b0);
      run_req(1'b0, 0, 0, 0, 0, 1'b1);
      run_req(1'b1, 0, 0, 0, 0, 1'b1);
      run_req(1'b0, 13, 3, 0, 0, 1'b1);
      run_req(1'b1, 9, 1, 0, 0, 1'b1);
      run_req(1'b0, 20, 0, 2, 0, 1'b1);
      run_req(1'b1, 11, 2, 3, 0, 1'b1);
      run_req(1'b0, 12, 0, 0, 2, 1'b1);
      run_req(1'b0, 9, 2, 0, 0, 1'b1);
      for (int r = 0; r < 8; r++) begin
         run_req(1'($urandom_range(0, 1)), $urandom_range(1, 24), $urandom_range(0, 3), 0, 0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
